cheby_series_ctrl: RTL and testbench
====================================

// Module: cheby_series_ctrl
// PURPOSE
//  Sequencer/arbiter for the per-point Chebyshev T ROMs (T_k(x_j), one ROM per x_j on a shared tristate bus).
//  On c_start it selects one ROM (one-hot CE/tristate enable), walks k=0..N_TERMS-1 and fetches T_k(x_j)
//  alongside coefficient c_k. It accumulates y = sum c_k*T_k(x_j) in Q1.15 and presents saturated y with a valid pulse.
//  Sits between filter control and the T ROM bank plus coefficient store.
// PARAMETERS
//  NUM_X    4   number of T ROMs (x points) sharing the data bus
//  SEL_W    2   width of i_x_sel (>= clog2(NUM_X))
//  ADDR_W   3   ROM/coef address width
//  N_TERMS  8   series length, 1..2^ADDR_W
//  ACC_W    36  accumulator width, signed, >= 35
// PORTS
//  c_clk             in   1       clock, all state on rising edge
//  c_rst             in   1       synchronous reset, active-high
//  c_start           in   1       request pulse, sampled only in IDLE
//  i_x_sel           in   SEL_W   ROM index j for this request
//  i_coef            in   16      c_k, signed Q1.15, combinational from o_coef_addr
//  o_coef_addr       out  ADDR_W  coefficient index k
//  o_rom_address     out  ADDR_W  T ROM address k, common to all ROMs
//  o_rom_read_en     out  1       ROM read enable, common
//  o_rom_ce          out  NUM_X   one-hot chip enable, active-high
//  o_rom_tri_output  out  NUM_X   per-ROM output tristate, 0 = drive bus
//  i_rom_data        in   16      shared ROM data bus, T_k signed Q1.15
//  o_y               out  16      result, signed Q1.15, held until next result
//  o_valid           out  1       one-cycle pulse, o_y updated
//  o_busy            out  1       high in FETCH/MAC/DONE
//  o_err             out  1       one-cycle pulse, c_start with i_x_sel >= NUM_X
// BEHAVIOUR
//  Reset: state=IDLE. o_y=0, o_valid=0, o_busy=0, o_err=0, o_rom_ce=0, o_rom_tri_output=all 1, o_rom_read_en=0.
//   Addresses=0, acc=0, k=0. Reset wins over every other event, including mid-sequence.
//  FSM: IDLE -> FETCH -> MAC -> (FETCH | DONE) -> IDLE.
//  IDLE: on c_start & i_x_sel<NUM_X: latch sel, clear acc, k=0, go FETCH.
//   On c_start & i_x_sel>=NUM_X: o_err=1 next cycle, stay IDLE, no bus activity.
//  FETCH (1 cyc): o_rom_address=o_coef_addr=k; o_rom_ce[sel]=1, o_rom_tri_output[sel]=0, read_en=1.
//   All other ROMs: ce=0, tri=1. At cycle end, register i_rom_data->t_reg and i_coef->c_reg.
//  MAC (1 cyc): all ROMs ce=0, tri=1 (bus released). acc += sext(c_reg*t_reg), 32b signed product.
//   If k==N_TERMS-1: go DONE. Else k++, go FETCH.
//  DONE (1 cyc): o_y = sat16(acc >>> 15), arithmetic shift, truncate toward -inf.
//   Clamp to 0x7FFF / 0x8000. o_valid=1 in this cycle only. Next state IDLE.
//  Latency: c_start at edge t -> o_valid high in cycle t+2*N_TERMS+1 (17 cycles for N_TERMS=8).
//   Back-to-back: next c_start accepted the cycle after DONE.
//  c_start while o_busy=1: ignored, not queued. i_x_sel is only sampled at acceptance.
//  Bus safety: at most one o_rom_tri_output bit is 0 in any cycle. It is 0 only during FETCH.
//  No accumulator overflow for N_TERMS<=8 with ACC_W>=35. Saturation applies only at output.
//  o_err and o_valid never assert in the same cycle.
// TESTING
//  1 Bench ROM x0 all 0x7FFF; c0=0x7FFF, c1..7=0 -> o_y=0x7FFE. o_valid exactly 17 cycles after start.
//  2 ROM x3 (T1=0xF000); c1=0x4000, others 0 -> o_y=0xF800. Only ce[3]/tri[3] toggle, only in FETCH cycles.
//  3 All T=0x7FFF, all c=0x7FFF -> o_y=0x7FFF (sat). All T=0x7FFF, all c=0x8000 -> o_y=0x8000 (sat).
//  4 c_start with i_x_sel=5 (NUM_X=4) -> o_err one cycle, o_busy stays 0, no ce/tri activity.
//  5 Extra c_start pulses during busy, plus a start the cycle after DONE -> exactly two o_valid pulses, two correct results.
//  6 c_rst asserted in MAC of k=3 -> next cycle all outputs at reset values.
//   A following request completes normally with a fresh accumulator.

Source files
------------

// File: rtl/cheby_series_ctrl.sv
// Chebyshev series sequencer: selects one T ROM on the shared bus, walks k, and
// accumulates y = sum c_k*T_k(x_j) in Q1.15, presenting a saturated result with a valid pulse.
module cheby_series_ctrl #(
  parameter int NUM_X   = 4,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 3,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 36
) (
  input  logic              c_clk,
  input  logic              c_rst,
  input  logic              c_start,
  input  logic [SEL_W-1:0]  i_x_sel,
  input  logic [15:0]       i_coef,
  output logic [ADDR_W-1:0] o_coef_addr,
  output logic [ADDR_W-1:0] o_rom_address,
  output logic              o_rom_read_en,
  output logic [NUM_X-1:0]  o_rom_ce,
  output logic [NUM_X-1:0]  o_rom_tri_output,
  input  logic [15:0]       i_rom_data,
  output logic [15:0]       o_y,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_err
);

  // state | meaning
  // IDLE  | waiting for c_start, bus released
  // FETCH | selected ROM drives bus, T_k and c_k captured at cycle end
  // MAC   | bus released, acc += c_k*T_k, then next k or DONE
  // DONE  | o_y/o_valid presented for one cycle, still busy
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_DONE} state_t;

  localparam logic [SEL_W:0]         NUM_X_L = (SEL_W + 1)'(NUM_X);
  localparam logic [ADDR_W-1:0]      K_LAST  = ADDR_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX  = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] Y_MIN  = ACC_W'(-32'sd32768);

  state_t                   state;
  logic [SEL_W-1:0]         sel;
  logic [ADDR_W-1:0]        k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [15:0]       t_reg;
  logic signed [15:0]       c_reg;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [15:0]              y_sat;
  logic [NUM_X-1:0]         start_mask;
  logic [NUM_X-1:0]         sel_mask;

  assign prod       = c_reg * t_reg;
  assign acc_nxt    = acc + ACC_W'(prod);
  assign acc_shr    = acc_nxt >>> 15;
  assign start_mask = NUM_X'(1) << i_x_sel;
  assign sel_mask   = NUM_X'(1) << sel;

  // Saturation is applied only to the presented result; the accumulator never wraps.
  always_comb begin
    y_sat = acc_shr[15:0];
    if (acc_shr > Y_MAX)      y_sat = 16'h7FFF;
    else if (acc_shr < Y_MIN) y_sat = 16'h8000;
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state            <= S_IDLE;
      sel              <= '0;
      k                <= '0;
      acc              <= '0;
      t_reg            <= '0;
      c_reg            <= '0;
      o_coef_addr      <= '0;
      o_rom_address    <= '0;
      o_rom_read_en    <= 1'b0;
      o_rom_ce         <= '0;
      o_rom_tri_output <= '1;
      o_y              <= '0;
      o_valid          <= 1'b0;
      o_busy           <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_start) begin
            if ({1'b0, i_x_sel} < NUM_X_L) begin
              sel              <= i_x_sel;
              acc              <= '0;
              k                <= '0;
              o_coef_addr      <= '0;
              o_rom_address    <= '0;
              o_rom_read_en    <= 1'b1;
              o_rom_ce         <= start_mask;
              o_rom_tri_output <= ~start_mask;
              o_busy           <= 1'b1;
              state            <= S_FETCH;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          t_reg            <= i_rom_data;
          c_reg            <= i_coef;
          o_rom_read_en    <= 1'b0;
          o_rom_ce         <= '0;
          o_rom_tri_output <= '1;
          state            <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (k == K_LAST) begin
            o_y     <= y_sat;
            o_valid <= 1'b1;
            state   <= S_DONE;
          end else begin
            k                <= k + ADDR_W'(1);
            o_coef_addr      <= k + ADDR_W'(1);
            o_rom_address    <= k + ADDR_W'(1);
            o_rom_read_en    <= 1'b1;
            o_rom_ce         <= sel_mask;
            o_rom_tri_output <= ~sel_mask;
            state            <= S_FETCH;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cheby_series_ctrl.sv
// Self-checking bench for cheby_series_ctrl: ROM bank and coefficient store modelled as arrays,
// results checked against a plain integer sum-of-products reference.
module tb_cheby_series_ctrl;

  localparam int NUM_X = 4;
  localparam int SEL_W = 3;
  localparam int ADDR_W = 3;
  localparam int N_TERMS = 8;

  logic              c_clk = 1'b0;
  logic              c_rst;
  logic              c_start;
  logic [SEL_W-1:0]  i_x_sel;
  logic [15:0]       i_coef;
  logic [ADDR_W-1:0] o_coef_addr;
  logic [ADDR_W-1:0] o_rom_address;
  logic              o_rom_read_en;
  logic [NUM_X-1:0]  o_rom_ce;
  logic [NUM_X-1:0]  o_rom_tri_output;
  logic [15:0]       i_rom_data;
  logic [15:0]       o_y;
  logic              o_valid;
  logic              o_busy;
  logic              o_err;

  cheby_series_ctrl #(.NUM_X(NUM_X), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .N_TERMS(N_TERMS), .ACC_W(36)) dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_start(c_start), .i_x_sel(i_x_sel), .i_coef(i_coef),
    .o_coef_addr(o_coef_addr), .o_rom_address(o_rom_address), .o_rom_read_en(o_rom_read_en),
    .o_rom_ce(o_rom_ce), .o_rom_tri_output(o_rom_tri_output), .i_rom_data(i_rom_data),
    .o_y(o_y), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 c_clk = ~c_clk;

  logic [15:0] rom [NUM_X][N_TERMS];
  logic [15:0] coef [N_TERMS];

  // Shared bus: the ROM whose tristate is low drives it; otherwise it floats to a poison value.
  always_comb begin
    i_rom_data = 16'hA5A5;
    for (int j = 0; j < NUM_X; j++)
      if (!o_rom_tri_output[j]) i_rom_data = rom[j][o_rom_address];
    i_coef = coef[o_coef_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cur_sel = 0;
  int fetch_cnt = 0;
  int valid_cnt = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge c_clk) begin
    if (o_valid) valid_cnt++;
    if (o_rom_ce != 0) fetch_cnt++;
    if (mon_en) begin
      logic [NUM_X-1:0] want;
      bit ok;
      want = 4'b0001 << cur_sel;
      ok = (o_rom_tri_output == ~o_rom_ce) && !(o_err && o_valid);
      if (o_rom_ce != 0) ok = ok && (o_rom_ce == want) && o_rom_read_en && o_busy;
      check("bus_safety", {ok}, 32'd1);
    end
  end

  function automatic logic [15:0] model(input int sel);
    longint s = 0;
    for (int kk = 0; kk < N_TERMS; kk++)
      s += longint'($signed(coef[kk])) * longint'($signed(rom[sel][kk]));
    s = s >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic run_req(input int sel, output logic [15:0] y, output int lat);
    @(negedge c_clk);
    c_start = 1'b1; i_x_sel = SEL_W'(sel); cur_sel = sel; fetch_cnt = 0;
    @(negedge c_clk);
    c_start = 1'b0;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge c_clk);
      lat++;
    end
    y = o_y;
    check("fetch_count", fetch_cnt, N_TERMS);
  endtask

  typedef struct packed {
    logic [2:0]        sel;
    logic [7:0][15:0]  t;
    logic [7:0][15:0]  c;
    logic [15:0]       exp_y;
  } vec_t;

  vec_t vecs [6];
  logic [15:0] y;
  int lat;

  initial begin
    // {sel, T[7..0], c[7..0], expected y}
    vecs[0] = '{3'd0, {8{16'h7FFF}}, {112'h0, 16'h7FFF}, 16'h7FFE};
    vecs[1] = '{3'd3, {16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hF000, 16'h7FFF},
                {96'h0, 16'h4000, 16'h0000}, 16'hF800};
    vecs[2] = '{3'd1, {8{16'h7FFF}}, {8{16'h7FFF}}, 16'h7FFF};
    vecs[3] = '{3'd2, {8{16'h7FFF}}, {8{16'h8000}}, 16'h8000};
    vecs[4] = '{3'd1, {8{16'h4000}}, {8{16'h1000}}, 16'h4000};
    vecs[5] = '{3'd2, {8{16'hFFFF}}, {112'h0, 16'h0001}, 16'hFFFF};

    for (int j = 0; j < NUM_X; j++)
      for (int kk = 0; kk < N_TERMS; kk++) rom[j][kk] = 16'h0;
    for (int kk = 0; kk < N_TERMS; kk++) coef[kk] = 16'h0;

    c_rst = 1'b1; c_start = 1'b0; i_x_sel = '0;
    repeat (3) @(negedge c_clk);
    check("rst_y", o_y, 0);
    check("rst_valid_busy_err", {o_valid, o_busy, o_err}, 0);
    check("rst_ce", o_rom_ce, 0);
    check("rst_tri", o_rom_tri_output, 4'hF);
    check("rst_rd_addr", {o_rom_read_en, o_rom_address, o_coef_addr}, 0);
    c_rst = 1'b0;
    mon_en = 1;

    for (int v = 0; v < 6; v++) begin
      for (int kk = 0; kk < N_TERMS; kk++) begin
        rom[vecs[v].sel][kk] = vecs[v].t[kk];
        coef[kk] = vecs[v].c[kk];
      end
      run_req(int'(vecs[v].sel), y, lat);
      check($sformatf("vec%0d_y", v), y, vecs[v].exp_y);
      check($sformatf("vec%0d_latency", v), lat, 17);
    end

    // Out-of-range select: error pulse only, no bus activity.
    @(negedge c_clk);
    c_start = 1'b1; i_x_sel = 3'd5;
    @(negedge c_clk);
    c_start = 1'b0;
    check("err_pulse", {o_err, o_busy}, 2'b10);
    check("err_no_bus", {o_rom_ce, o_rom_tri_output, o_rom_read_en}, {4'h0, 4'hF, 1'b0});
    @(negedge c_clk);
    check("err_one_cycle", {o_err, o_busy}, 2'b00);

    // Starts while busy are dropped; a start right after DONE is taken.
    for (int kk = 0; kk < N_TERMS; kk++) begin
      rom[0][kk] = 16'h1000 + 16'(kk * 16'h0300);
      rom[1][kk] = 16'hC000 + 16'(kk * 16'h0700);
      coef[kk] = 16'h2000 - 16'(kk * 16'h0500);
    end
    valid_cnt = 0;
    @(negedge c_clk);
    c_start = 1'b1; i_x_sel = 3'd0; cur_sel = 0;
    @(negedge c_clk);
    c_start = 1'b0;
    lat = 1;
    while (!o_valid && lat < 40) begin
      c_start = (lat % 4 == 0);
      i_x_sel = 3'd1;
      @(negedge c_clk);
      lat++;
    end
    c_start = 1'b0;
    check("b2b_first_y", o_y, model(0));
    check("b2b_first_latency", lat, 17);
    run_req(1, y, lat);
    check("b2b_second_y", y, model(1));
    check("b2b_second_latency", lat, 17);
    @(negedge c_clk);
    check("b2b_valid_count", valid_cnt, 2);

    // Reset during MAC of k=3, then a clean request.
    for (int kk = 0; kk < N_TERMS; kk++) begin
      rom[2][kk] = 16'h3000 - 16'(kk * 16'h0800);
      coef[kk] = 16'h1800 + 16'(kk * 16'h0100);
    end
    @(negedge c_clk);
    c_start = 1'b1; i_x_sel = 3'd2; cur_sel = 2;
    @(negedge c_clk);
    c_start = 1'b0;
    lat = 1;
    while (lat < 8) begin
      @(negedge c_clk);
      lat++;
    end
    check("mac_k3_state", {o_busy, o_rom_ce, o_rom_address}, {1'b1, 4'h0, 3'd3});
    c_rst = 1'b1;
    @(negedge c_clk);
    c_rst = 1'b0;
    check("midrst_y", o_y, 0);
    check("midrst_flags", {o_valid, o_busy, o_err, o_rom_read_en}, 0);
    check("midrst_bus", {o_rom_ce, o_rom_tri_output}, {4'h0, 4'hF});
    check("midrst_addr", {o_rom_address, o_coef_addr}, 0);
    run_req(2, y, lat);
    check("post_rst_y", y, model(2));
    check("post_rst_latency", lat, 17);

    // Random requests against the reference sum.
    for (int r = 0; r < 20; r++) begin
      int s;
      s = int'($urandom_range(NUM_X - 1, 0));
      for (int kk = 0; kk < N_TERMS; kk++) begin
        rom[s][kk] = 16'($urandom);
        coef[kk] = (r % 2 == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(8191, 0))) - 16'sd4096);
      end
      run_req(s, y, lat);
      check($sformatf("rand%0d_y", r), y, model(s));
      check($sformatf("rand%0d_latency", r), lat, 17);
    end

    repeat (2) @(negedge c_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
